// File: rtl/fp_mul.sv
// fp_mul: iterative unsigned fixed-point multiplier.
//
// Multiplies two unsigned Q(WIDTH-FRACTION_WIDTH).FRACTION_WIDTH operands into one
// product in the same format. It consumes BITS_PER_CYCLE multiplier bits per
// iteration with shift-add accumulation into a 2*WIDTH-bit accumulator. The handshake
// matches fp_div (accept when valid_in && !busy, one-cycle valid_out pulse), so both
// units can share the same control. One operation is in flight at a time.
//
// Latency: if the request is accepted at edge E0, valid_out is high in the cycle
// after edge E(N_ITER+1). The latency does not depend on the operand values.
//
// Build option: define FP_MUL_ROUND_EN to round half-up, which adds
// 2^(FRACTION_WIDTH-1) before truncation. The overflow check then uses the rounded
// value. With the macro undefined the result is truncated toward zero.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_in           synchronous active-high reset
//   multiplicand_in  operand A (WIDTH bits)
//   multiplier_in    operand B (WIDTH bits)
//   valid_in         request strobe, ignored while busy
//   product_out      registered result, saturates to all ones on overflow
//   overflow_out     registered saturation flag, qualified by valid_out
//   valid_out        registered single-cycle result pulse
//   busy             registered, high while an operation is in flight
module fp_mul #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned FRACTION_WIDTH = 10,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] product_out,
  output logic             overflow_out,
  output logic             valid_out,
  output logic             busy
);

  localparam int unsigned NIter  = (WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int unsigned BWidth = NIter * BITS_PER_CYCLE;
  localparam int unsigned CntW   = $clog2(NIter + 1);
  localparam int unsigned AccW   = 2 * WIDTH;

  localparam logic [CntW-1:0] CntLast = CntW'(NIter);

  typedef enum logic [0:0] {StIdle, StIter} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [BWidth-1:0] b_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  product_q;
  logic              overflow_q;
  logic              valid_q;
  logic              busy_q;

  logic [BITS_PER_CYCLE-1:0] digit;
  logic [AccW-1:0]           partial;
  logic [31:0]               shamt;
  logic [AccW-1:0]           rounded;
  logic                      sat;
  logic                      start;

  assign start = valid_in && !busy_q;

  // Partial product A*d placed at the weight of the current digit. Bits above B's
  // top are zero, so truncating each term to AccW bits loses nothing.
  always_comb begin
    digit   = b_q[BITS_PER_CYCLE-1:0];
    shamt   = 32'(cnt_q) * BITS_PER_CYCLE;
    partial = (AccW'(a_q) * AccW'(digit)) << shamt;
  end

`ifdef FP_MUL_ROUND_EN
  localparam logic [AccW-1:0] RoundHalf = AccW'(1) << (FRACTION_WIDTH - 1);
  // The sum is at most (2^WIDTH-1)^2 + 2^(FRACTION_WIDTH-1), so it cannot carry out.
  assign rounded = acc_q + RoundHalf;
`else
  assign rounded = acc_q;
`endif

  assign sat = |rounded[AccW-1:WIDTH+FRACTION_WIDTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= multiplicand_in;
            b_q     <= BWidth'(multiplier_in);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StIter;
          end
        end
        StIter: begin
          if (cnt_q == CntLast) begin
            // Finish edge: the accumulator now holds the exact product.
            if (sat) begin
              product_q  <= '1;
              overflow_q <= 1'b1;
            end else begin
              product_q  <= rounded[WIDTH+FRACTION_WIDTH-1:FRACTION_WIDTH];
              overflow_q <= 1'b0;
            end
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_q + partial;
            b_q   <= b_q >> BITS_PER_CYCLE;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign product_out  = product_q;
  assign overflow_out = overflow_q;
  assign valid_out    = valid_q;
  assign busy         = busy_q;

endmodule
